// File: rtl/neighbor_output_sender.sv
// Transmit side of the 8-way neighbor halo exchange.
// Activations that fall in the current kernel's halo border are queued for
// each neighbor that needs them and sent as that neighbor signals
// clear-to-send. A small FSM then closes the channel group with the
// exchange_done / cycle_done handshake.
// Neighbor index: 0 N, 1 NE, 2 E, 3 SE, 4 S, 5 SW, 6 W, 7 NW.
module neighbor_output_sender #(
  parameter int unsigned TILE_SIZE  = 256,
  parameter int unsigned TILE_DIM   = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned CW        = $clog2(TILE_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          kernel_size,
  input  logic [7:0]          in_value,
  input  logic [CW-1:0]       in_row,
  input  logic [CW-1:0]       in_column,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                channel_group_done,
  input  logic [7:0]          neighbor_enable,
  input  logic [7:0]          neighbor_cts,
  input  logic [7:0]          neighbor_exchange_done,
  output logic [7:0][7:0]     neighbor_output_value,
  output logic [7:0][CW-1:0]  neighbor_output_row,
  output logic [7:0][CW-1:0]  neighbor_output_column,
  output logic [7:0]          neighbor_output_write_enable,
  output logic                exchange_done,
  output logic                cycle_done
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 8 + 2 * CW;

  localparam logic [1:0] ST_STREAM = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_SIGNAL = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;

  logic [EW-1:0] r_mem    [8][FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr [8];
  logic [PW-1:0] r_rd_ptr [8];
  logic [PW:0]   r_count  [8];

  logic [2:0]    w_halo;
  logic [CW-1:0] w_h_ext;
  logic [CW-1:0] w_far_edge;
  logic          w_top, w_bottom, w_left, w_right;
  logic [7:0]    w_target;
  logic [7:0]    w_full;
  logic [7:0]    w_push;
  logic [7:0]    w_pop;
  logic          w_accept;
  logic          w_all_empty;
  logic          w_peers_done;
  logic [EW-1:0] w_entry;

  // Halo region classification of the offered activation
  always_comb begin
    w_halo     = kernel_size >> 1;
    w_h_ext    = CW'(w_halo);
    w_far_edge = CW'(TILE_DIM) - w_h_ext;
    // h == 0 disables every flag, including the far-edge compares
    w_top      = (w_halo != 3'd0) && (in_row < w_h_ext);
    w_bottom   = (w_halo != 3'd0) && (in_row >= w_far_edge);
    w_left     = (w_halo != 3'd0) && (in_column < w_h_ext);
    w_right    = (w_halo != 3'd0) && (in_column >= w_far_edge);
    w_target   = neighbor_enable & {w_top & w_left, w_left, w_bottom & w_left, w_bottom,
                                    w_bottom & w_right, w_right, w_top & w_right, w_top};
  end

  // Queue status, accept and per-neighbor push/pop decisions
  always_comb begin
    w_all_empty = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w_full[i] = (r_count[i] == (PW + 1)'(FIFO_DEPTH));
      w_pop[i]  = (r_count[i] != '0) && neighbor_cts[i];
      if (r_count[i] != '0) w_all_empty = 1'b0;
    end
    // Full is judged before any same-cycle pop, so accept never overflows
    in_ready     = (r_state == ST_STREAM) && (w_full == 8'd0);
    w_accept     = in_valid && in_ready;
    // Zero activations are consumed but never forwarded
    w_push       = (w_accept && (in_value != 8'd0)) ? w_target : 8'd0;
    w_entry      = {in_value, in_row, in_column};
    w_peers_done = &(neighbor_exchange_done | ~neighbor_enable);
  end

  // Queue storage; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= w_entry;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        if (w_push[i] && !w_pop[i])      r_count[i] <= r_count[i] + 1'b1;
        else if (!w_push[i] && w_pop[i]) r_count[i] <= r_count[i] - 1'b1;
      end
    end
  end

  // Output registers: load the popped head and strobe write_enable next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      neighbor_output_value        <= '0;
      neighbor_output_row          <= '0;
      neighbor_output_column       <= '0;
      neighbor_output_write_enable <= '0;
    end else begin
      neighbor_output_write_enable <= w_pop;
      for (int i = 0; i < 8; i++) begin
        if (w_pop[i]) begin
          {neighbor_output_value[i], neighbor_output_row[i], neighbor_output_column[i]}
              <= r_mem[i][r_rd_ptr[i]];
        end
      end
    end
  end

  // Channel-group handshake next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_STREAM: if (channel_group_done) w_state_next = ST_DRAIN;
      // Wait for the final strobe to leave as well as the queues to empty
      ST_DRAIN:  if (w_all_empty && (neighbor_output_write_enable == 8'd0))
                   w_state_next = ST_SIGNAL;
      ST_SIGNAL: if (w_peers_done) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = ST_STREAM;
      default:   w_state_next = ST_STREAM;
    endcase
  end

  // Handshake state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_STREAM;
    else       r_state <= w_state_next;
  end

  assign exchange_done = (r_state == ST_SIGNAL);
  assign cycle_done    = (r_state == ST_DONE);

endmodule
